// File: rtl/csr_bank.sv
// rtl/csr_bank.sv - Machine-mode CSR bank: counters, trap entry/return and a one-cycle read/modify/write port.
module csr_bank #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned HART_ID    = 0,
    parameter logic [31:0] MIMPID_VAL = 32'h0000_0001
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req_valid,
    input  logic [1:0]      req_op,
    input  logic [11:0]     req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [1:0]      priv,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_illegal,
    input  logic            instret_inc,
    input  logic            exc_valid,
    input  logic [XLEN-1:0] exc_cause,
    input  logic [XLEN-1:0] exc_pc,
    input  logic [XLEN-1:0] exc_tval,
    input  logic            mret_valid,
    output logic [XLEN-1:0] mtvec_o,
    output logic [XLEN-1:0] mepc_o,
    output logic            mie_o
);

    localparam logic [1:0] OP_NONE  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_SET   = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_MVENDORID = 12'hF11;
    localparam logic [11:0] A_MARCHID   = 12'hF12;
    localparam logic [11:0] A_MIMPID    = 12'hF13;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    localparam logic [1:0]      MXL       = (XLEN == 64) ? 2'd2 : 2'd1;
    localparam logic [XLEN-1:0] MISA_VAL  = {MXL, {(XLEN-11){1'b0}}, 9'h100};
    localparam logic [XLEN-1:0] EPC_MASK  = ~XLEN'(3);
    localparam bit              HAS_HIGH  = (XLEN == 32);

    logic            st_mie_q,   st_mie_d;
    logic            st_mpie_q,  st_mpie_d;
    logic [XLEN-1:0] mie_q,      mie_d;
    logic [XLEN-1:0] mtvec_q,    mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q,     mepc_d;
    logic [XLEN-1:0] mcause_q,   mcause_d;
    logic [XLEN-1:0] mtval_q,    mtval_d;
    logic [63:0]     mcycle_q,   mcycle_d;
    logic [63:0]     minstret_q, minstret_d;

    logic            resp_valid_q,   resp_valid_d;
    logic            resp_illegal_q, resp_illegal_d;
    logic [XLEN-1:0] resp_rdata_q,   resp_rdata_d;

    logic [XLEN-1:0] rd_val;
    logic            implemented;
    logic            wr_attempt;
    logic            illegal;
    logic            do_write;
    logic [XLEN-1:0] wval;

    // Read mux and address decode; unimplemented addresses fall through with implemented=0.
    always_comb begin
        rd_val      = '0;
        implemented = 1'b1;
        case (req_addr)
            A_MSTATUS: begin
                rd_val[12:11] = 2'b11;
                rd_val[7]     = st_mpie_q;
                rd_val[3]     = st_mie_q;
            end
            A_MISA:      rd_val = MISA_VAL;
            A_MIE:       rd_val = mie_q;
            A_MTVEC:     rd_val = mtvec_q;
            A_MSCRATCH:  rd_val = mscratch_q;
            A_MEPC:      rd_val = mepc_q;
            A_MCAUSE:    rd_val = mcause_q;
            A_MTVAL:     rd_val = mtval_q;
            A_MIP:       rd_val = '0;
            A_MCYCLE:    rd_val = mcycle_q[XLEN-1:0];
            A_MINSTRET:  rd_val = minstret_q[XLEN-1:0];
            A_MCYCLEH: begin
                if (HAS_HIGH) rd_val = XLEN'(mcycle_q[63:32]);
                else          implemented = 1'b0;
            end
            A_MINSTRETH: begin
                if (HAS_HIGH) rd_val = XLEN'(minstret_q[63:32]);
                else          implemented = 1'b0;
            end
            A_MVENDORID: rd_val = '0;
            A_MARCHID:   rd_val = '0;
            A_MIMPID:    rd_val = XLEN'(MIMPID_VAL);
            A_MHARTID:   rd_val = XLEN'(HART_ID);
            default:     implemented = 1'b0;
        endcase
    end

    // Set/clear with a zero operand is a pure read, so it may target read-only CSRs.
    always_comb begin
        wr_attempt = (req_op == OP_WRITE) ||
                     (((req_op == OP_SET) || (req_op == OP_CLEAR)) && (|req_wdata));
        illegal    = !implemented || (priv < req_addr[9:8]) ||
                     (wr_attempt && (req_addr[11:10] == 2'b11));
        do_write   = req_valid && wr_attempt && !illegal && !exc_valid;
        case (req_op)
            OP_WRITE: wval = req_wdata;
            OP_SET:   wval = rd_val | req_wdata;
            OP_CLEAR: wval = rd_val & ~req_wdata;
            default:  wval = rd_val;
        endcase
    end

    always_comb begin
        st_mie_d   = st_mie_q;
        st_mpie_d  = st_mpie_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + {63'd0, instret_inc};

        if (do_write) begin
            case (req_addr)
                A_MSTATUS: begin
                    st_mie_d  = wval[3];
                    st_mpie_d = wval[7];
                end
                A_MIE:      mie_d      = wval;
                A_MTVEC:    mtvec_d    = {wval[XLEN-1:2], wval[1] ? mtvec_q[1:0] : wval[1:0]};
                A_MSCRATCH: mscratch_d = wval;
                A_MEPC:     mepc_d     = wval & EPC_MASK;
                A_MCAUSE:   mcause_d   = wval;
                A_MTVAL:    mtval_d    = wval;
                // A counter write freezes the untouched half too, so a split 32-bit load is exact.
                A_MCYCLE: begin
                    mcycle_d = mcycle_q;
                    mcycle_d[XLEN-1:0] = wval;
                end
                A_MINSTRET: begin
                    minstret_d = minstret_q;
                    minstret_d[XLEN-1:0] = wval;
                end
                A_MCYCLEH: begin
                    if (HAS_HIGH) begin
                        mcycle_d = mcycle_q;
                        mcycle_d[63:32] = wval[31:0];
                    end
                end
                A_MINSTRETH: begin
                    if (HAS_HIGH) begin
                        minstret_d = minstret_q;
                        minstret_d[63:32] = wval[31:0];
                    end
                end
                default: ;
            endcase
        end

        if (exc_valid) begin
            mepc_d    = exc_pc & EPC_MASK;
            mcause_d  = exc_cause;
            mtval_d   = exc_tval;
            st_mpie_d = st_mie_q;
            st_mie_d  = 1'b0;
        end else if (mret_valid) begin
            st_mie_d  = st_mpie_q;
            st_mpie_d = 1'b1;
        end
    end

    always_comb begin
        resp_valid_d   = req_valid;
        resp_illegal_d = req_valid && illegal && !exc_valid;
        resp_rdata_d   = (req_valid && !resp_illegal_d) ? rd_val : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            st_mie_q       <= 1'b0;
            st_mpie_q      <= 1'b0;
            mie_q          <= '0;
            mtvec_q        <= '0;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
            mcycle_q       <= '0;
            minstret_q     <= '0;
            resp_valid_q   <= 1'b0;
            resp_illegal_q <= 1'b0;
            resp_rdata_q   <= '0;
        end else begin
            st_mie_q       <= st_mie_d;
            st_mpie_q      <= st_mpie_d;
            mie_q          <= mie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
            mcycle_q       <= mcycle_d;
            minstret_q     <= minstret_d;
            resp_valid_q   <= resp_valid_d;
            resp_illegal_q <= resp_illegal_d;
            resp_rdata_q   <= resp_rdata_d;
        end
    end

    assign resp_valid   = resp_valid_q;
    assign resp_illegal = resp_illegal_q;
    assign resp_rdata   = resp_rdata_q;
    assign mtvec_o      = mtvec_q;
    assign mepc_o       = mepc_q;
    assign mie_o        = st_mie_q;

endmodule

// File: tb/tb_csr_bank.sv
// tb/tb_csr_bank.sv - Directed and randomized checks of csr_bank against a behavioural CSR model.
module tb_csr_bank;

    localparam int unsigned HART = 5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  priv;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_illegal;
    logic        instret_inc;
    logic        exc_valid;
    logic [31:0] exc_cause;
    logic [31:0] exc_pc;
    logic [31:0] exc_tval;
    logic        mret_valid;
    logic [31:0] mtvec_o;
    logic [31:0] mepc_o;
    logic        mie_o;

    csr_bank #(.XLEN(32), .HART_ID(HART), .MIMPID_VAL(32'h0000_0001)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
        .req_wdata(req_wdata), .priv(priv),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_illegal(resp_illegal),
        .instret_inc(instret_inc), .exc_valid(exc_valid), .exc_cause(exc_cause),
        .exc_pc(exc_pc), .exc_tval(exc_tval), .mret_valid(mret_valid),
        .mtvec_o(mtvec_o), .mepc_o(mepc_o), .mie_o(mie_o)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Architectural state as the model sees it.
    bit          m_mie, m_mpie;
    logic [31:0] m_mie_r, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    logic [63:0] m_cyc, m_ins;

    logic [11:0] addr_tab [0:19] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340,
                                     12'h341, 12'h342, 12'h343, 12'h344, 12'hB00,
                                     12'hB02, 12'hB80, 12'hB82, 12'hF11, 12'hF12,
                                     12'hF13, 12'hF14, 12'h345, 12'h7C0, 12'hC00};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void m_read(input logic [11:0] a, output logic [31:0] v, output bit impl);
        impl = 1'b1;
        case (a)
            12'h300: v = 32'h1800 + (m_mpie ? 32'h80 : 32'h0) + (m_mie ? 32'h8 : 32'h0);
            12'h301: v = 32'h4000_0100;
            12'h304: v = m_mie_r;
            12'h305: v = m_mtvec;
            12'h340: v = m_mscratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'h343: v = m_mtval;
            12'h344: v = 32'h0;
            12'hB00: v = m_cyc[31:0];
            12'hB02: v = m_ins[31:0];
            12'hB80: v = m_cyc[63:32];
            12'hB82: v = m_ins[63:32];
            12'hF11, 12'hF12: v = 32'h0;
            12'hF13: v = 32'h1;
            12'hF14: v = HART;
            default: begin v = 32'h0; impl = 1'b0; end
        endcase
    endfunction

    task automatic m_reset();
        m_mie = 0; m_mpie = 0;
        m_mie_r = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
        m_cyc = 0; m_ins = 0;
    endtask

    // One clock: predict from the current inputs, advance, compare every output.
    task automatic tick();
        logic [31:0] old, nv, e_rd;
        bit impl, wr, ill, e_val, e_ill, p_mie, p_mpie;
        logic [63:0] cyc_n, ins_n;
        if (!reset_n) begin
            e_val = 0; e_ill = 0; e_rd = 0;
            m_reset();
        end else begin
            m_read(req_addr, old, impl);
            wr    = (req_op == 2'd1) || (req_op >= 2'd2 && req_wdata != 0);
            ill   = !impl || (priv < req_addr[9:8]) || (wr && req_addr[11:10] == 2'b11);
            e_val = req_valid;
            e_ill = req_valid && ill && !exc_valid;
            e_rd  = (req_valid && !e_ill) ? old : 32'h0;
            case (req_op)
                2'd1:    nv = req_wdata;
                2'd2:    nv = old | req_wdata;
                2'd3:    nv = old & ~req_wdata;
                default: nv = old;
            endcase
            p_mie = m_mie; p_mpie = m_mpie;
            cyc_n = m_cyc + 1;
            ins_n = m_ins + (instret_inc ? 1 : 0);
            if (req_valid && wr && !ill && !exc_valid) begin
                case (req_addr)
                    12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                    12'h304: m_mie_r = nv;
                    12'h305: m_mtvec = (nv[1:0] < 2) ? nv : {nv[31:2], m_mtvec[1:0]};
                    12'h340: m_mscratch = nv;
                    12'h341: m_mepc = {nv[31:2], 2'b00};
                    12'h342: m_mcause = nv;
                    12'h343: m_mtval = nv;
                    12'hB00: cyc_n = {m_cyc[63:32], nv};
                    12'hB80: cyc_n = {nv, m_cyc[31:0]};
                    12'hB02: ins_n = {m_ins[63:32], nv};
                    12'hB82: ins_n = {nv, m_ins[31:0]};
                    default: ;
                endcase
            end
            if (exc_valid) begin
                m_mepc = {exc_pc[31:2], 2'b00};
                m_mcause = exc_cause;
                m_mtval = exc_tval;
                m_mpie = p_mie;
                m_mie = 0;
            end else if (mret_valid) begin
                m_mie = p_mpie;
                m_mpie = 1;
            end
            m_cyc = cyc_n;
            m_ins = ins_n;
        end
        @(posedge clk);
        #1;
        check("resp_valid", resp_valid, e_val);
        check("resp_illegal", resp_illegal, e_ill);
        check("resp_rdata", resp_rdata, e_rd);
        check("mtvec_o", mtvec_o, m_mtvec);
        check("mepc_o", mepc_o, m_mepc);
        check("mie_o", mie_o, m_mie);
    endtask

    task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd);
        req_valid = 1; req_op = op; req_addr = a; req_wdata = wd;
        tick();
        req_valid = 0; req_op = 0; req_addr = 0; req_wdata = 0;
    endtask

    initial begin
        reset_n = 0; req_valid = 1; req_op = 2'd1; req_addr = 12'h340; req_wdata = 32'hFF;
        priv = 2'd3; instret_inc = 0; exc_valid = 0; exc_cause = 0; exc_pc = 0;
        exc_tval = 0; mret_valid = 0;
        m_reset();
        tick();
        tick();
        check("reset resp_valid", resp_valid, 1'b0);
        check("reset resp_rdata", resp_rdata, 32'h0);
        req_valid = 0; req_op = 0; req_addr = 0; req_wdata = 0;
        reset_n = 1;

        // mtvec mode 3 is rejected, old mode kept
        csr(2'd1, 12'h305, 32'h8000_0003);
        check("mtvec wr old", resp_rdata, 32'h0);
        check("mtvec wr ill", resp_illegal, 1'b0);
        csr(2'd0, 12'h305, 32'h0);
        check("mtvec rd", resp_rdata, 32'h8000_0000);

        // trap entry then return
        csr(2'd2, 12'h300, 32'h8);
        exc_valid = 1; exc_pc = 32'h104; exc_cause = 32'h2;
        tick();
        exc_valid = 0;
        check("exc mie_o", mie_o, 1'b0);
        check("exc mepc_o", mepc_o, 32'h104);
        csr(2'd0, 12'h300, 32'h0);
        check("mstatus after exc", resp_rdata, 32'h1880);
        mret_valid = 1;
        tick();
        mret_valid = 0;
        csr(2'd0, 12'h300, 32'h0);
        check("mstatus after mret", resp_rdata, 32'h1888);

        // read-only space: write illegal, zero-operand set legal
        csr(2'd1, 12'hF14, 32'h1);
        check("mhartid wr ill", resp_illegal, 1'b1);
        check("mhartid wr rdata", resp_rdata, 32'h0);
        csr(2'd2, 12'hF14, 32'h0);
        check("mhartid set0 ill", resp_illegal, 1'b0);
        check("mhartid set0 rdata", resp_rdata, HART);

        priv = 2'd0;
        csr(2'd0, 12'h340, 32'h0);
        check("user mscratch ill", resp_illegal, 1'b1);
        priv = 2'd3;

        // 64-bit cycle counter wrap through split halves
        csr(2'd1, 12'hB00, 32'hFFFF_FFFF);
        csr(2'd1, 12'hB80, 32'hFFFF_FFFF);
        tick();
        tick();
        csr(2'd0, 12'hB00, 32'h0);
        check("mcycle wrap lo", resp_rdata, 32'h1);
        csr(2'd0, 12'hB80, 32'h0);
        check("mcycle wrap hi", resp_rdata, 32'h0);

        // trap discards same-cycle write
        csr(2'd1, 12'h340, 32'h1234);
        exc_valid = 1; exc_pc = 32'h200; exc_cause = 32'h7; exc_tval = 32'hABC;
        csr(2'd1, 12'h340, 32'h55);
        exc_valid = 0;
        check("exc resp ill", resp_illegal, 1'b0);
        check("exc resp rdata", resp_rdata, 32'h1234);
        check("exc mepc", mepc_o, 32'h200);
        csr(2'd0, 12'h340, 32'h0);
        check("mscratch kept", resp_rdata, 32'h1234);

        reset_n = 0; req_valid = 1; req_op = 2'd0; req_addr = 12'h300;
        tick();
        req_valid = 0;
        reset_n = 1;
        check("rst resp_valid", resp_valid, 1'b0);
        check("rst mtvec_o", mtvec_o, 32'h0);
        check("rst mepc_o", mepc_o, 32'h0);
        check("rst mie_o", mie_o, 1'b0);
        csr(2'd0, 12'hB00, 32'h0);
        check("rst mcycle", resp_rdata, 32'h0);
        csr(2'd0, 12'h300, 32'h0);
        check("rst mstatus", resp_rdata, 32'h1800);
        csr(2'd0, 12'h340, 32'h0);
        check("rst mscratch", resp_rdata, 32'h0);
        csr(2'd0, 12'h342, 32'h0);
        check("rst mcause", resp_rdata, 32'h0);

        for (int i = 0; i < 600; i++) begin
            reset_n     = ($urandom_range(0, 59) != 0);
            req_valid   = ($urandom_range(0, 3) != 0);
            req_op      = 2'($urandom_range(0, 3));
            req_addr    = addr_tab[$urandom_range(0, 19)];
            req_wdata   = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            priv        = 2'($urandom_range(0, 3));
            instret_inc = $urandom_range(0, 1) != 0;
            exc_valid   = ($urandom_range(0, 9) == 0);
            exc_cause   = $urandom;
            exc_pc      = $urandom;
            exc_tval    = $urandom;
            mret_valid  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 29) == 0) begin
                req_addr  = ($urandom_range(0, 1) != 0) ? 12'hB00 : 12'hB02;
                req_op    = 2'd1;
                req_wdata = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/csr_bank.md
CSR_BANK -- requirements
Module: csr_bank

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the register width; the only legal values are 32 and 64.
REQ-002 The block SHALL have parameter HART_ID, default 0, meaning the value read from mhartid.
REQ-003 The block SHALL have parameter MIMPID_VAL, default 32'h0000_0001, meaning the value read from mimpid.
REQ-004 The block SHALL have ports as follows:
 clk  in  1  clock; all state SHALL update on the rising edge.
 reset_n  in  1  synchronous, active-low reset.
 req_valid  in  1  CSR access request this cycle.
 req_op  in  2  csr_ops encoding: none=0, write=1, set=2, clear=3.
 req_addr  in  12  CSR address.
 req_wdata  in  XLEN  operand (rs1 value or zero-extended immediate).
 priv  in  2  current Privilege (USER=0, MACHINE=3).
 resp_valid  out  1  response strobe.
 resp_rdata  out  XLEN  old CSR value.
 resp_illegal  out  1  access was illegal.
 instret_inc  in  1  one instruction retired.
 exc_valid  in  1  trap entry.
 exc_cause  in  XLEN  value for mcause.
 exc_pc  in  XLEN  value for mepc.
 exc_tval  in  XLEN  value for mtval.
 mret_valid  in  1  trap return.
 mtvec_o  out  XLEN  current mtvec.
 mepc_o  out  XLEN  current mepc.
 mie_o  out  1  mstatus.MIE.

Function
REQ-005 The implemented CSRs SHALL be mstatus 0x300, misa 0x301, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344, mcycle 0xB00, minstret 0xB02, mvendorid 0xF11, marchid 0xF12, mimpid 0xF13 and mhartid 0xF14, plus mcycleh 0xB80 and minstreth 0xB82 when XLEN=32 only.
REQ-006 A request accepted in cycle N SHALL produce resp_valid=1 in cycle N+1, with registered resp_rdata holding the pre-update value; there SHALL be no back-pressure, and one request per cycle SHALL be supported.
REQ-007 The new value SHALL be: for write, wdata; for set, old|wdata; for clear, old&~wdata; for none, no write.
REQ-008 For set or clear with wdata=0, the block SHALL perform no write and SHALL NOT raise the read-only illegal check.
REQ-009 resp_illegal SHALL be 1 for any of the following: an unimplemented address; priv < req_addr[9:8]; or a write attempt to an address with req_addr[11:10]=2'b11. When resp_illegal=1, resp_rdata SHALL be 0 and no state SHALL change.
REQ-010 mstatus SHALL store only MIE (bit 3), MPIE (bit 7) and MPP (bits 12:11).
REQ-011 mstatus.MPP SHALL always read 2'b11, and all other mstatus bits SHALL read 0.
REQ-012 misa SHALL read MXL (1 for XLEN=32, 2 for XLEN=64) in the top two bits, with bit 8 (I) set; writes to misa SHALL be ignored and SHALL NOT be flagged illegal.
REQ-013 mtvec writes SHALL keep mode bits [1:0] only if the written mode is 0 or 1; otherwise the old mode SHALL be retained.
REQ-014 mepc bits [1:0] SHALL always read 0.
REQ-015 mip SHALL be read-only zero, and writes to mip SHALL be ignored.
REQ-016 mcycle SHALL be 64 bits wide, SHALL increment by 1 every cycle out of reset, and SHALL wrap from all-ones to 0.
REQ-017 minstret SHALL be 64 bits wide, SHALL increment when instret_inc=1, and SHALL wrap from all-ones to 0.
REQ-018 With XLEN=32, the low and high counter halves SHALL be written independently.
REQ-019 A CSR write to a counter SHALL take precedence over that counter's increment in the same cycle.
REQ-020 On exc_valid, the block SHALL set mepc=exc_pc, mcause=exc_cause, mtval=exc_tval, mstatus.MPIE=MIE and mstatus.MIE=0, all in the same cycle.
REQ-021 On mret_valid, the block SHALL set mstatus.MIE=MPIE and mstatus.MPIE=1.
REQ-022 exc_valid SHALL take priority over mret_valid and over a same-cycle CSR write, which SHALL be discarded; resp_valid SHALL still assert, with the old value and resp_illegal=0.
REQ-023 mret_valid SHALL take priority over a same-cycle write to mstatus only.
REQ-024 mtvec_o, mepc_o and mie_o SHALL reflect register state after the clock edge (registered, no combinational bypass).

Reset
REQ-025 When reset_n=0 at a clock edge, the block SHALL clear mstatus (MIE=0, MPIE=0), mie, mtvec, mscratch, mepc, mcause, mtval, mcycle and minstret to 0.
REQ-026 When reset_n=0 at a clock edge, the block SHALL force resp_valid=0, resp_illegal=0 and resp_rdata=0.
REQ-027 Reset mid-request SHALL drop the request with no response.

Verification
REQ-028 A bench SHALL cover: write 0x305 wdata=0x8000_0003 -> next cycle rdata=0, resp_illegal=0; a following read returns 0x8000_0000 (mode retained as 0).
REQ-029 A bench SHALL cover: set 0x300 wdata=0x8, then exc_valid with exc_pc=0x104 and exc_cause=0x2 -> mstatus reads 0x1880, mepc=0x104, mie_o=0; then mret_valid -> mstatus reads 0x1888.
REQ-030 A bench SHALL cover: write 0xF14 wdata=1 -> resp_illegal=1, rdata=0; set 0xF14 wdata=0 -> resp_illegal=0, rdata=HART_ID.
REQ-031 A bench SHALL cover: priv=0 read of 0x340 -> resp_illegal=1.
REQ-032 A bench SHALL cover, with XLEN=32: write mcycle=0xFFFF_FFFF and mcycleh=0xFFFF_FFFF, then idle 2 cycles -> mcycle reads 0x1 and mcycleh reads 0 (wrap).
REQ-033 A bench SHALL cover: same cycle exc_valid and write to 0x340 wdata=0x55 -> mscratch unchanged, mepc=exc_pc; then reset_n=0 for one cycle -> all outputs and registers at their REQ-025/REQ-026 values.
